// File: rtl/blk_cdd90a.sv
// Read side of a generic CDC FIFO: pulls entries from a synchronous-read memory into a 2-entry
// skid buffer feeding an AXI4-Stream master. Optional level outputs: LOGIC_CDC_READ_LEVEL_EN.
module blk_cdd90a #(
    parameter int unsigned DATA_WIDTH    = 1,
    parameter int unsigned ADDRESS_WIDTH = 3,
    parameter int unsigned ALMOST_EMPTY  = 2
) (
    input  logic                    tx_aclk,
    input  logic                    tx_areset_n,
    output logic                    tx_tvalid,
    output logic [DATA_WIDTH-1:0]   tx_tdata,
    input  logic                    tx_tready,
    output logic                    read_enable,
    output logic [ADDRESS_WIDTH:0]  read_pointer,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic [ADDRESS_WIDTH:0]  write_pointer_synced,
    output logic [ADDRESS_WIDTH:0]  tx_level,
    output logic                    tx_almost_empty
);

    localparam int unsigned PtrW = ADDRESS_WIDTH + 1;

    if (DATA_WIDTH < 1) begin : gen_drc_data_width
        $error("DATA_WIDTH must be >= 1");
    end
    if (ADDRESS_WIDTH < 2) begin : gen_drc_address_width
        $error("ADDRESS_WIDTH must be >= 2");
    end
    if (ALMOST_EMPTY >= (1 << ADDRESS_WIDTH)) begin : gen_drc_almost_empty
        $error("ALMOST_EMPTY must be < 2**ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {
        StOutEmpty = 2'd0,
        StOutOne   = 2'd1,
        StOutTwo   = 2'd2
    } out_state_e;

    out_state_e            state_q, state_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                  inflight_q;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;

    logic [PtrW-1:0] occupancy;
    logic            empty;
    logic            pop;
    logic            capture;
    logic [1:0]      stored;
    logic [2:0]      demand;

    // Pointer difference modulo 2**PtrW; the extra MSB tells full from empty.
    assign occupancy = write_pointer_synced - rd_ptr_q;
    assign empty     = (occupancy == '0);
    assign capture   = inflight_q;
    assign pop       = tx_tvalid & tx_tready;

    // Entries already held or on their way, after this cycle's pop, must leave room for one more.
    assign demand      = {1'b0, stored} + {2'b00, inflight_q} - {2'b00, pop};
    assign read_enable = run_q & ~empty & (demand < 3'd2);

    assign rd_ptr_d     = rd_ptr_q + {{ADDRESS_WIDTH{1'b0}}, read_enable};
    assign read_pointer = rd_ptr_q;

    // run_q holds reads off until the first clock edge after reset release.
    always_ff @(posedge tx_aclk or negedge tx_areset_n) begin
        if (!tx_areset_n) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= read_enable;
            run_q      <= 1'b1;
        end
    end

    always_ff @(posedge tx_aclk or negedge tx_areset_n) begin
        if (!tx_areset_n) begin
            state_q <= StOutEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOutEmpty: if (capture) state_d = StOutOne;
            StOutOne: begin
                if (capture && !pop) begin
                    state_d = StOutTwo;
                end else if (!capture && pop) begin
                    state_d = StOutEmpty;
                end
            end
            StOutTwo:   if (pop) state_d = StOutOne;
            default:    state_d = StOutEmpty;
        endcase
    end

    always_comb begin
        tx_tvalid = 1'b0;
        stored    = 2'd0;
        case (state_q)
            StOutOne: begin
                tx_tvalid = 1'b1;
                stored    = 2'd1;
            end
            StOutTwo: begin
                tx_tvalid = 1'b1;
                stored    = 2'd2;
            end
            default: begin
                tx_tvalid = 1'b0;
                stored    = 2'd0;
            end
        endcase
    end

    // entry0 is always the oldest entry; entry1 only fills when entry0 is stalled.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (state_q)
            StOutEmpty: if (capture) entry0_d = read_data;
            StOutOne: begin
                if (capture && pop) begin
                    entry0_d = read_data;
                end else if (capture) begin
                    entry1_d = read_data;
                end
            end
            StOutTwo:   if (pop) entry0_d = entry1_q;
            default:    entry0_d = entry0_q;
        endcase
    end

    always_ff @(posedge tx_aclk) begin
        entry0_q <= entry0_d;
        entry1_q <= entry1_d;
    end

    assign tx_tdata = entry0_q;

`ifdef LOGIC_CDC_READ_LEVEL_EN
    localparam logic [PtrW-1:0] AlmostEmptyThr = PtrW'(ALMOST_EMPTY);

    logic [PtrW-1:0] level_q;
    logic            almost_empty_q;

    always_ff @(posedge tx_aclk or negedge tx_areset_n) begin
        if (!tx_areset_n) begin
            level_q        <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= occupancy;
            almost_empty_q <= (occupancy <= AlmostEmptyThr);
        end
    end

    assign tx_level        = level_q;
    assign tx_almost_empty = almost_empty_q;
`else
    assign tx_level        = '0;
    assign tx_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_blk_cdd90a.sv
// Bench for blk_cdd90a: directed vector table, hand-written corner sequences and a random
// phase checked against a queue-based reference model of the read buffer.
module tb_blk_cdd90a;

    localparam int unsigned Dw = 8;
    localparam int unsigned Aw = 3;
`ifdef LOGIC_CDC_READ_LEVEL_EN
    localparam bit LevelEn = 1'b1;
`else
    localparam bit LevelEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          areset_n;
    logic          tvalid;
    logic [Dw-1:0] tdata;
    logic          tready;
    logic          re;
    logic [Aw:0]   rptr;
    logic [Dw-1:0] rdata;
    logic [Aw:0]   wptr;
    logic [Aw:0]   level;
    logic          ae;

    always #5 clk = ~clk;

    blk_cdd90a #(
        .DATA_WIDTH    (Dw),
        .ADDRESS_WIDTH (Aw),
        .ALMOST_EMPTY  (2)
    ) dut (
        .tx_aclk              (clk),
        .tx_areset_n          (areset_n),
        .tx_tvalid            (tvalid),
        .tx_tdata             (tdata),
        .tx_tready            (tready),
        .read_enable          (re),
        .read_pointer         (rptr),
        .read_data            (rdata),
        .write_pointer_synced (wptr),
        .tx_level             (level),
        .tx_almost_empty      (ae)
    );

    // Synchronous-read memory behind the DUT.
    logic [Dw-1:0] mem [8];
    always @(posedge clk) if (re) rdata <= mem[rptr[Aw-1:0]];

    // Reference model: output buffer as a queue, one pending read, level registers.
    logic [Dw-1:0] m_q[$];
    logic [Aw:0]   m_rptr;
    logic          m_inflight;
    logic [Dw-1:0] m_inflight_data;
    logic [Aw:0]   m_level;
    logic          m_ae;
    logic          m_run;
    logic          m_pop;
    logic          m_re;
    logic [Aw:0]   m_occ;

    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            re_count = 0;
    logic [Dw-1:0] dut_log[$];
    int            pop_cycles[$];

    typedef struct {
        logic [Aw:0]   wp;
        logic          rdy;
        logic          tv;
        logic [Dw-1:0] td;
        logic          re;
        logic [Aw:0]   rp;
    } vec_t;
    vec_t tbl[12];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rptr     = '0;
        m_inflight = 1'b0;
        m_level    = '0;
        m_ae       = 1'b1;
        m_run      = 1'b0;
    endtask

    task automatic check_model();
        logic exp_tv;
        m_occ  = wptr - m_rptr;
        exp_tv = (m_q.size() != 0);
        m_pop  = exp_tv && tready;
        m_re   = m_run && (m_occ != 0) &&
                 ((m_q.size() + int'(m_inflight) - int'(m_pop)) < 2);
        cmp("tvalid", 32'(tvalid), 32'(exp_tv));
        if (exp_tv) cmp("tdata", 32'(tdata), 32'(m_q[0]));
        cmp("read_enable", 32'(re), 32'(m_re));
        cmp("read_pointer", 32'(rptr), 32'(m_rptr));
        cmp("tx_level", 32'(level), LevelEn ? 32'(m_level) : 32'd0);
        cmp("tx_almost_empty", 32'(ae), LevelEn ? 32'(m_ae) : 32'd0);
        if (tvalid && tready) begin
            dut_log.push_back(tdata);
            pop_cycles.push_back(cyc);
        end
        if (re) re_count++;
    endtask

    task automatic step_model();
        if (m_pop) m_q.delete(0);
        if (m_inflight) m_q.push_back(m_inflight_data);
        m_inflight = m_re;
        if (m_re) begin
            m_inflight_data = mem[m_rptr[Aw-1:0]];
            m_rptr          = m_rptr + 1'b1;
        end
        m_level = m_occ;
        m_ae    = (m_occ <= 2);
        m_run   = 1'b1;
        cyc++;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input logic [Aw:0] wp, input logic rdy);
        wptr   = wp;
        tready = rdy;
        #4;
        check_model();
        @(posedge clk);
        #1;
        step_model();
    endtask

    task automatic clear_logs();
        dut_log.delete();
        pop_cycles.delete();
        re_count = 0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        wptr     = '0;
        tready   = 1'b0;
        #2;
        model_reset();
        cmp("rst_tvalid", 32'(tvalid), 32'd0);
        cmp("rst_read_enable", 32'(re), 32'd0);
        cmp("rst_read_pointer", 32'(rptr), 32'd0);
        cmp("rst_tx_level", 32'(level), 32'd0);
        cmp("rst_tx_almost_empty", 32'(ae), LevelEn ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        int          total;
        logic [Aw:0] w;
        logic [Aw:0] occ;

        areset_n = 1'b0;
        wptr     = '0;
        tready   = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = Dw'($urandom);
        model_reset();

        tbl[0]  = '{4'd0, 1'b1, 1'b0, 8'h00,  1'b0, 4'd0};
        tbl[1]  = '{4'd1, 1'b1, 1'b0, 8'h00,  1'b1, 4'd0};
        tbl[2]  = '{4'd1, 1'b1, 1'b0, 8'h00,  1'b0, 4'd1};
        tbl[3]  = '{4'd1, 1'b1, 1'b1, mem[0], 1'b0, 4'd1};
        tbl[4]  = '{4'd1, 1'b1, 1'b0, 8'h00,  1'b0, 4'd1};
        tbl[5]  = '{4'd3, 1'b1, 1'b0, 8'h00,  1'b1, 4'd1};
        tbl[6]  = '{4'd3, 1'b1, 1'b0, 8'h00,  1'b1, 4'd2};
        tbl[7]  = '{4'd3, 1'b0, 1'b1, mem[1], 1'b0, 4'd3};
        tbl[8]  = '{4'd3, 1'b0, 1'b1, mem[1], 1'b0, 4'd3};
        tbl[9]  = '{4'd3, 1'b1, 1'b1, mem[1], 1'b0, 4'd3};
        tbl[10] = '{4'd3, 1'b1, 1'b1, mem[2], 1'b0, 4'd3};
        tbl[11] = '{4'd3, 1'b1, 1'b0, 8'h00,  1'b0, 4'd3};

        @(posedge clk);
        #1;
        do_reset();

        // Single entry, then two entries with a two-cycle stall.
        for (int i = 0; i < 12; i++) begin
            wptr   = tbl[i].wp;
            tready = tbl[i].rdy;
            #4;
            cmp("tbl_tvalid", 32'(tvalid), 32'(tbl[i].tv));
            if (tbl[i].tv) cmp("tbl_tdata", 32'(tdata), 32'(tbl[i].td));
            cmp("tbl_read_enable", 32'(re), 32'(tbl[i].re));
            cmp("tbl_read_pointer", 32'(rptr), 32'(tbl[i].rp));
            check_model();
            @(posedge clk);
            #1;
            step_model();
        end

        // Full burst drains back-to-back.
        do_reset();
        repeat (14) cycle(4'd8, 1'b1);
        cmp("burst_count", 32'(dut_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) cmp("burst_data", 32'(dut_log[i]), 32'(mem[i]));
        if (pop_cycles.size() == 8) cmp("burst_gapless", 32'(pop_cycles[7] - pop_cycles[0]), 32'd7);
        cmp("burst_rptr", 32'(rptr), 32'd8);

        // Backpressure: at most two reads while stalled.
        do_reset();
        repeat (8) cycle(4'd5, 1'b0);
        cmp("bp_reads", 32'(re_count), 32'd2);
        cmp("bp_tvalid", 32'(tvalid), 32'd1);
        cmp("bp_tdata", 32'(tdata), 32'(mem[0]));
        repeat (10) cycle(4'd5, 1'b1);
        cmp("bp_count", 32'(dut_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++) cmp("bp_data", 32'(dut_log[i]), 32'(mem[i]));
        cmp("bp_total_reads", 32'(re_count), 32'd5);

        // Pointer wrap: 15 -> 1 across the MSB.
        do_reset();
        repeat (14) cycle(4'd8, 1'b1);
        repeat (12) cycle(4'd15, 1'b1);
        cmp("wrap_pre_rptr", 32'(rptr), 32'd15);
        clear_logs();
        repeat (8) cycle(4'd1, 1'b1);
        cmp("wrap_count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            cmp("wrap_data0", 32'(dut_log[0]), 32'(mem[7]));
            cmp("wrap_data1", 32'(dut_log[1]), 32'(mem[0]));
        end
        cmp("wrap_rptr", 32'(rptr), 32'd1);

        // Level outputs lag occupancy by one cycle.
        do_reset();
        repeat (2) cycle(4'd0, 1'b0);
        cycle(4'd3, 1'b0);
        cmp("lvl_three", 32'(level), LevelEn ? 32'd3 : 32'd0);
        cmp("lvl_ae_low", 32'(ae), 32'd0);
        cycle(4'd3, 1'b0);
        cmp("lvl_two", 32'(level), LevelEn ? 32'd2 : 32'd0);
        cmp("lvl_ae_high", 32'(ae), LevelEn ? 32'd1 : 32'd0);

        // Reset mid-operation with the buffer full.
        do_reset();
        repeat (5) cycle(4'd5, 1'b0);
        #2;
        areset_n = 1'b0;
        #1;
        cmp("mid_rst_tvalid", 32'(tvalid), 32'd0);
        cmp("mid_rst_rptr", 32'(rptr), 32'd0);
        cmp("mid_rst_re", 32'(re), 32'd0);
        model_reset();
        wptr = '0;
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        clear_logs();
        repeat (5) cycle(4'd0, 1'b1);
        cmp("mid_rst_no_stale", 32'(dut_log.size()), 32'd0);
        repeat (5) cycle(4'd1, 1'b1);
        cmp("mid_rst_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() == 1) cmp("mid_rst_data", 32'(dut_log[0]), 32'(mem[0]));

        // Random writer and ready pattern; output stream must be mem[0], mem[1], ... cyclically.
        do_reset();
        w     = '0;
        total = 0;
        repeat (400) begin
            occ = w - m_rptr;
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k     = int'($urandom_range(0, 8 - int'(occ)));
                w     = w + 4'(k);
                total = total + k;
            end
            cycle(w, ($urandom_range(0, 3) != 0));
        end
        repeat (20) cycle(w, 1'b1);
        cmp("rand_rptr", 32'(rptr), 32'(w));
        cmp("rand_count", 32'(dut_log.size()), 32'(total));
        for (int i = 0; i < dut_log.size(); i++) begin
            if (dut_log[i] !== mem[i % 8]) cmp("rand_order", 32'(dut_log[i]), 32'(mem[i % 8]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
